// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU main control:
// opcodes, FSM states, datapath select codes and the control bundle.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQ    = 4'd9,
        S_BNE    = 4'd10,
        S_JMP    = 4'd11,
        S_ADDIEX = 4'd12,
        S_ADDIWB = 4'd13
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_if_zero;
        logic       pc_if_nonzero;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
               (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state (+ mem_ready in FETCH) to control-signal table.
// Unlisted and unused states decode to all zeros.
module multicycle_control_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_MEM = 1
) (
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output logic       illegal_op
);

    logic rdy;

    assign rdy = (WAIT_MEM == 0) || mem_ready;

    always_comb begin
        ctrl       = '0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read      = 1'b1;
                ctrl.alu_src_b     = SRCB_4;
                ctrl.alu_op        = ALU_ADD;
                ctrl.pc_source     = PC_ALU;
                ctrl.ir_write      = rdy;
                ctrl.pc_write      = rdy;
                ctrl.pc_if_zero    = rdy;
                ctrl.pc_if_nonzero = rdy;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                illegal_op     = !op_legal(op);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_RTEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PC_ALUOUT;
                ctrl.pc_write      = 1'b1;
                ctrl.pc_if_zero    = (state == S_BEQ);
                ctrl.pc_if_nonzero = (state == S_BNE);
            end
            S_JMP: begin
                ctrl.pc_source     = PC_JUMP;
                ctrl.pc_write      = 1'b1;
                ctrl.pc_if_zero    = 1'b1;
                ctrl.pc_if_nonzero = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: state register and next-state
// logic; the output table lives in multicycle_control_decode.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_MEM = 1,
    parameter int STATE_W  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteIfZero,
    output logic       PCWriteIfNonZero,
    output logic       illegal_op
);

    logic [STATE_W-1:0] state;
    state_t             cur;
    state_t             nxt;
    ctrl_t              ctrl;
    logic               rdy;

    assign cur = state_t'(state[ST_W-1:0]);
    assign rdy = (WAIT_MEM == 0) || mem_ready;

    always_comb begin
        nxt = S_RST;
        case (cur)
            S_RST:    nxt = S_FETCH;
            S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_RTEX;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_BNE:       nxt = S_BNE;
                    OP_J:         nxt = S_JMP;
                    OP_ADDI:      nxt = S_ADDIEX;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
            S_RTEX:   nxt = S_RTWB;
            S_RTWB:   nxt = S_FETCH;
            S_BEQ:    nxt = S_FETCH;
            S_BNE:    nxt = S_FETCH;
            S_JMP:    nxt = S_FETCH;
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: nxt = S_FETCH;
            default:  nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= STATE_W'(S_RST);
        else       state <= STATE_W'(nxt);
    end

    multicycle_control_decode #(
        .WAIT_MEM (WAIT_MEM)
    ) u_decode (
        .state      (cur),
        .op         (op),
        .mem_ready  (mem_ready),
        .ctrl       (ctrl),
        .illegal_op (illegal_op)
    );

    assign MemRead          = ctrl.mem_read;
    assign MemWrite         = ctrl.mem_write;
    assign IorD             = ctrl.iord;
    assign IRWrite          = ctrl.ir_write;
    assign RegWrite         = ctrl.reg_write;
    assign RegDst           = ctrl.reg_dst;
    assign MemtoReg         = ctrl.mem_to_reg;
    assign ALUSrcA          = ctrl.alu_src_a;
    assign ALUSrcB          = ctrl.alu_src_b;
    assign ALUOp            = ctrl.alu_op;
    assign PCSource         = ctrl.pc_source;
    assign PCWrite          = ctrl.pc_write;
    assign PCWriteIfZero    = ctrl.pc_if_zero;
    assign PCWriteIfNonZero = ctrl.pc_if_nonzero;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: every output is packed
// into one word and compared against hand-written per-state constants.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst;
    logic       MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       PCWrite, PCWriteIfZero, PCWriteIfNonZero, illegal_op;

    int vec_cnt = 0;
    int err_cnt = 0;

    // MR MW IorD IRW RW RD M2R ASA ASB AOP PCS PCW IZ INZ ILL
    localparam logic [17:0] V_ZERO    = 18'b0_0_0_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] V_FETCH   = 18'b1_0_0_1_0_0_0_0_01_00_00_1_1_1_0;
    localparam logic [17:0] V_FSTALL  = 18'b1_0_0_0_0_0_0_0_01_00_00_0_0_0_0;
    localparam logic [17:0] V_DECODE  = 18'b0_0_0_0_0_0_0_0_11_00_00_0_0_0_0;
    localparam logic [17:0] V_DEC_ILL = 18'b0_0_0_0_0_0_0_0_11_00_00_0_0_0_1;
    localparam logic [17:0] V_MEMADR  = 18'b0_0_0_0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [17:0] V_MEMRD   = 18'b1_0_1_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] V_MEMWB   = 18'b0_0_0_0_1_0_1_0_00_00_00_0_0_0_0;
    localparam logic [17:0] V_MEMWR   = 18'b0_1_1_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] V_RTEX    = 18'b0_0_0_0_0_0_0_1_00_10_00_0_0_0_0;
    localparam logic [17:0] V_RTWB    = 18'b0_0_0_0_1_1_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] V_BEQ     = 18'b0_0_0_0_0_0_0_1_00_01_01_1_1_0_0;
    localparam logic [17:0] V_BNE     = 18'b0_0_0_0_0_0_0_1_00_01_01_1_0_1_0;
    localparam logic [17:0] V_JMP     = 18'b0_0_0_0_0_0_0_0_00_00_10_1_1_1_0;
    localparam logic [17:0] V_ADDIWB  = 18'b0_0_0_0_1_0_0_0_00_00_00_0_0_0_0;

    logic [17:0] outs;
    assign outs = {MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst,
                   MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                   PCWrite, PCWriteIfZero, PCWriteIfNonZero, illegal_op};

    multicycle_control dut (
        .clk              (clk),
        .reset            (reset),
        .op               (op),
        .mem_ready        (mem_ready),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .IorD             (IorD),
        .IRWrite          (IRWrite),
        .RegWrite         (RegWrite),
        .RegDst           (RegDst),
        .MemtoReg         (MemtoReg),
        .ALUSrcA          (ALUSrcA),
        .ALUSrcB          (ALUSrcB),
        .ALUOp            (ALUOp),
        .PCSource         (PCSource),
        .PCWrite          (PCWrite),
        .PCWriteIfZero    (PCWriteIfZero),
        .PCWriteIfNonZero (PCWriteIfNonZero),
        .illegal_op       (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [17:0] got,
                         input logic [17:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 'x;
        mem_ready = 1'b1;
        repeat (2) tick();
        check("rst_hold", outs, V_ZERO);
        reset = 1'b0;
        #1;
        check("rst_released", outs, V_ZERO);
        tick();
        check("fetch_first", outs, V_FETCH);

        // LW: FETCH, DECODE, MEMADR, MEMRD, MEMWB
        op = 6'b100011;
        tick(); check("lw_decode", outs, V_DECODE);
        tick(); check("lw_memadr", outs, V_MEMADR);
        tick(); check("lw_memrd", outs, V_MEMRD);
        tick(); check("lw_memwb", outs, V_MEMWB);
        tick(); check("lw_done", outs, V_FETCH);

        // FETCH stalls while memory is not ready
        mem_ready = 1'b0;
        #1; check("fetch_stall", outs, V_FSTALL);
        tick(); check("fetch_stall2", outs, V_FSTALL);
        mem_ready = 1'b1;
        #1; check("fetch_go", outs, V_FETCH);

        // SW with three not-ready cycles in MEMWR
        op = 6'b101011;
        tick(); check("sw_decode", outs, V_DECODE);
        tick(); check("sw_memadr", outs, V_MEMADR);
        mem_ready = 1'b0;
        tick(); check("sw_memwr1", outs, V_MEMWR);
        tick(); check("sw_memwr2", outs, V_MEMWR);
        tick(); check("sw_memwr3", outs, V_MEMWR);
        mem_ready = 1'b1;
        #1; check("sw_memwr4", outs, V_MEMWR);
        tick(); check("sw_done", outs, V_FETCH);

        // BEQ then BNE
        op = 6'b000100;
        tick(); check("beq_decode", outs, V_DECODE);
        tick(); check("beq_exec", outs, V_BEQ);
        tick(); check("beq_done", outs, V_FETCH);
        op = 6'b000101;
        tick(); check("bne_decode", outs, V_DECODE);
        tick(); check("bne_exec", outs, V_BNE);
        tick(); check("bne_done", outs, V_FETCH);

        // R-type
        op = 6'b000000;
        tick(); check("rt_decode", outs, V_DECODE);
        tick(); check("rt_ex", outs, V_RTEX);
        tick(); check("rt_wb", outs, V_RTWB);
        tick(); check("rt_done", outs, V_FETCH);

        // ADDI
        op = 6'b001000;
        tick(); check("addi_decode", outs, V_DECODE);
        tick(); check("addi_ex", outs, V_MEMADR);
        tick(); check("addi_wb", outs, V_ADDIWB);
        tick(); check("addi_done", outs, V_FETCH);

        // J
        op = 6'b000010;
        tick(); check("j_decode", outs, V_DECODE);
        tick(); check("j_exec", outs, V_JMP);
        tick(); check("j_done", outs, V_FETCH);

        // Illegal opcode: one-cycle pulse in DECODE
        op = 6'b111111;
        tick(); check("ill_decode", outs, V_DEC_ILL);
        tick(); check("ill_done", outs, V_FETCH);

        // Reset in the middle of a stalled store
        op = 6'b101011;
        tick(); check("swr_decode", outs, V_DECODE);
        tick(); check("swr_memadr", outs, V_MEMADR);
        mem_ready = 1'b0;
        tick(); check("swr_memwr", outs, V_MEMWR);
        #2 reset = 1'b1;
        #1; check("swr_async_rst", outs, V_ZERO);
        tick(); check("swr_rst_hold", outs, V_ZERO);
        reset     = 1'b0;
        mem_ready = 1'b1;
        tick(); check("swr_restart", outs, V_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
